// File: rtl/vliw_fetch_unit.sv
// VLIW bundle fetch unit: credit-limited in-order fetch into a small bundle queue,
// with branch redirect that flushes the queue and discards in-flight responses.
module vliw_fetch_unit #(
    parameter int          BUNDLE_W = 320,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fetch_en,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [31:0]         imem_addr,
    input  logic                imem_rsp_valid,
    input  logic [BUNDLE_W-1:0] imem_rsp_data,
    output logic                bundle_valid,
    input  logic                bundle_ready,
    output logic [BUNDLE_W-1:0] bundle_data,
    output logic [31:0]         bundle_pc,
    output logic [9:0]          slot_mask
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   rpc_q, rpc_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] disc_q, disc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic          pend_q, pend_d;

    logic [BUNDLE_W-1:0] data_mem [DEPTH];
    logic [31:0]         pc_mem   [DEPTH];

    logic has_credit;
    logic req_fire;
    logic rsp_eff;
    logic rsp_push;
    logic pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credits cover both in-flight requests and queued bundles, so a response always fits.
    assign has_credit = ({1'b0, out_q} + {1'b0, cnt_q}) < (CW + 1)'(DEPTH);
    assign req_fire   = imem_req_valid && imem_req_ready;
    assign rsp_eff    = imem_rsp_valid && (out_q != '0);
    assign rsp_push   = rsp_eff && !redirect_valid && (disc_q == '0);
    assign pop        = bundle_valid && bundle_ready;
    assign imem_addr  = pc_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = (disc_d != '0) ? FLUSH : (fetch_en ? FETCH : IDLE);
        end else begin
            case (state_q)
                IDLE:    if (fetch_en) state_d = FETCH;
                FETCH:   if (!fetch_en) state_d = IDLE;
                FLUSH:   if (disc_d == '0) state_d = fetch_en ? FETCH : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output logic: a request already presented stays up until taken, even if fetch_en drops.
    always_comb begin
        imem_req_valid = 1'b0;
        if (!redirect_valid) begin
            imem_req_valid = pend_q || ((state_q == FETCH) && has_credit);
        end
    end

    always_comb begin
        pc_d   = pc_q;
        rpc_d  = rpc_q;
        out_d  = out_q + CW'(req_fire) - CW'(rsp_eff);
        disc_d = disc_q;
        pend_d = imem_req_valid && !imem_req_ready;
        cnt_d  = cnt_q + CW'(rsp_push) - CW'(pop);
        rd_d   = pop ? ptr_inc(rd_q) : rd_q;
        wr_d   = rsp_push ? ptr_inc(wr_q) : wr_q;
        if (req_fire) begin
            pc_d = pc_q + 32'd1;
        end
        if (rsp_push) begin
            rpc_d = rpc_q + 32'd1;
        end
        if (rsp_eff && (disc_q != '0)) begin
            disc_d = disc_q - 1'b1;
        end
        // Every request still in flight after a redirect belongs to the old path.
        if (redirect_valid) begin
            pc_d   = redirect_pc;
            rpc_d  = redirect_pc;
            disc_d = out_d;
            cnt_d  = '0;
            rd_d   = '0;
            wr_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            rpc_q  <= RESET_PC;
            out_q  <= '0;
            disc_q <= '0;
            cnt_q  <= '0;
            rd_q   <= '0;
            wr_q   <= '0;
            pend_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            rpc_q  <= rpc_d;
            out_q  <= out_d;
            disc_q <= disc_d;
            cnt_q  <= cnt_d;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            pend_q <= pend_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rsp_push) begin
            data_mem[wr_q] <= imem_rsp_data;
            pc_mem[wr_q]   <= rpc_q;
        end
    end

    assign bundle_valid = (cnt_q != '0);
    assign bundle_data  = bundle_valid ? data_mem[rd_q] : '0;
    assign bundle_pc    = bundle_valid ? pc_mem[rd_q] : '0;

    // Mask is MSB-aligned with the bundle: slot 0 (top word) drives slot_mask[9].
    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_slot
            assign slot_mask[gi] = |bundle_data[BUNDLE_W - 320 + 32*gi +: 32];
        end
    endgenerate

endmodule
